// File: rtl/phase_actuator_if.sv
// AXI-Stream bundle for phase_actuator: frequency and phase-offset sinks plus the phase source.
// The slave modport is the actuator's view; master is the upstream controller / downstream consumer.
interface phase_actuator_if #(
  parameter int AXIS_TDATA_WIDTH = 32
);
  logic [AXIS_TDATA_WIDTH-1:0] S_AXIS_FREQ_tdata;
  logic                        S_AXIS_FREQ_tvalid;
  logic                        S_AXIS_FREQ_tready;
  logic [AXIS_TDATA_WIDTH-1:0] S_AXIS_PHASE_tdata;
  logic                        S_AXIS_PHASE_tvalid;
  logic                        S_AXIS_PHASE_tready;
  logic [AXIS_TDATA_WIDTH-1:0] M_AXIS_PHASE_tdata;
  logic                        M_AXIS_PHASE_tvalid;

  modport slave (
    input  S_AXIS_FREQ_tdata, S_AXIS_FREQ_tvalid,
    output S_AXIS_FREQ_tready,
    input  S_AXIS_PHASE_tdata, S_AXIS_PHASE_tvalid,
    output S_AXIS_PHASE_tready,
    output M_AXIS_PHASE_tdata, M_AXIS_PHASE_tvalid
  );

  modport master (
    output S_AXIS_FREQ_tdata, S_AXIS_FREQ_tvalid,
    input  S_AXIS_FREQ_tready,
    output S_AXIS_PHASE_tdata, S_AXIS_PHASE_tvalid,
    input  S_AXIS_PHASE_tready,
    input  M_AXIS_PHASE_tdata, M_AXIS_PHASE_tvalid
  );
endinterface

// File: rtl/phase_actuator.sv
// Phase-ramp synthesiser: slews frequency toward a commanded target, accumulates phase, adds offset.
// Define PHASE_DITHER_EN to add LFSR dither below the truncation point.
module phase_actuator #(
  parameter int                     AXIS_TDATA_WIDTH = 32,
  parameter int                     ACCUM_WIDTH      = 32,
  parameter int                     PHASE_BITS       = 16,
  parameter logic [ACCUM_WIDTH-1:0] GUESS            = 'h10000000,
  parameter logic [ACCUM_WIDTH-1:0] RAMP_STEP        = 'h00100000,
  parameter logic [31:0]            SEED             = 32'd36421
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  phase_actuator_if.slave axis,
  output logic            ramp_active
);

  localparam int DW = ACCUM_WIDTH - PHASE_BITS;

  // A zero seed would lock the dither LFSR.
  if (SEED == '0) begin : g_bad_seed
    $error("phase_actuator: SEED must be nonzero");
  end

  typedef enum logic {IDLE, RAMP} state_t;

  state_t                 state, state_d;
  logic                   started;
  logic [ACCUM_WIDTH-1:0] acc, freq, freq_d, target, target_d, offset;
  logic [ACCUM_WIDTH-1:0] diff, diff_mag, dither, phase_sum;
  logic [PHASE_BITS-1:0]  phase_q;
  logic                   freq_hs, phase_hs;

  assign axis.S_AXIS_FREQ_tready  = started && (state == IDLE);
  assign axis.S_AXIS_PHASE_tready = started;
  assign axis.M_AXIS_PHASE_tvalid = started;
  assign axis.M_AXIS_PHASE_tdata  = AXIS_TDATA_WIDTH'(phase_q);
  assign ramp_active              = (state == RAMP);

  assign freq_hs  = axis.S_AXIS_FREQ_tvalid  && started && (state == IDLE);
  assign phase_hs = axis.S_AXIS_PHASE_tvalid && started;

`ifdef PHASE_DITHER_EN
  logic [31:0] lfsr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) lfsr <= SEED;
    else     lfsr <= {1'b0, lfsr[31:1]} ^ (lfsr[0] ? 32'h8020_0003 : 32'h0);
  end

  assign dither = ACCUM_WIDTH'(lfsr[DW-1:0]);
`else
  assign dither = '0;
`endif

  assign phase_sum = acc + offset + dither;

  // Magnitude is taken as unsigned so the most-negative difference stays larger than any step.
  always_comb begin
    state_d  = state;
    freq_d   = freq;
    target_d = target;
    diff     = target - freq;
    diff_mag = diff[ACCUM_WIDTH-1] ? (~diff + 1'b1) : diff;
    unique case (state)
      IDLE: begin
        if (freq_hs) begin
          target_d = ACCUM_WIDTH'(axis.S_AXIS_FREQ_tdata);
          state_d  = RAMP;
        end
      end
      RAMP: begin
        if (en) begin
          if (diff_mag <= RAMP_STEP) begin
            freq_d  = target;
            state_d = IDLE;
          end else if (diff[ACCUM_WIDTH-1]) begin
            freq_d = freq - RAMP_STEP;
          end else begin
            freq_d = freq + RAMP_STEP;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      started <= 1'b0;
      acc     <= '0;
      freq    <= GUESS;
      target  <= '0;
      offset  <= '0;
      phase_q <= '0;
    end else begin
      state   <= state_d;
      started <= 1'b1;
      freq    <= freq_d;
      target  <= target_d;
      phase_q <= PHASE_BITS'(phase_sum >> DW);
      if (en)       acc    <= acc + freq;
      if (phase_hs) offset <= ACCUM_WIDTH'(axis.S_AXIS_PHASE_tdata);
    end
  end

endmodule
